// File: rtl/vau_cmd_sequencer.sv
// rtl/vau_cmd_sequencer.sv - Wishbone command queue that issues vector-accelerator commands one at a time.
module vau_cmd_sequencer #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cmd_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    input  logic        vau_done_i,
    output logic        busy_o,
    output logic        irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              req_we_q, req_we_d;
    logic              req_ok_q, req_ok_d;
    logic [7:0]        req_off_q, req_off_d;
    logic [31:0]       req_dat_q, req_dat_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic              drained_q, drained_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              irq_q, irq_d;

    logic        hit, wr_en, push, push_ok, pop, ctrl_wr, full, empty;
    logic [31:0] rd_data, status_w;

    assign hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign full  = (count_q == DEPTH_V);
    assign empty = (count_q == '0);
    assign pop   = (state_q == ST_ISSUE) & cmd_ready_i;

    // Writes commit during the ack cycle from the request captured at the hit.
    assign wr_en   = ack_q & req_we_q & req_ok_q;
    assign push    = wr_en & (req_off_q == 8'h00);
    assign ctrl_wr = wr_en & (req_off_q == 8'h08);
    assign push_ok = push & ~full;

    assign status_w = {22'd0, drained_q, ovf_q, state_q, empty, full, 4'(count_q)};

    always_comb begin
        rd_data = 32'd0;
        case (wbs_adr_i[7:0])
            8'h04:   rd_data = status_w;
            8'h08:   rd_data = {29'd0, irq_en_q, 1'b0, enable_q};
            8'h0C:   rd_data = 32'(cyc_q);
            default: rd_data = 32'd0;
        endcase
    end

    always_comb begin
        ack_d     = hit & ~ack_q;
        dat_d     = (ack_d & ~wbs_we_i) ? rd_data : 32'd0;
        req_we_d  = req_we_q;
        req_ok_d  = req_ok_q;
        req_off_d = req_off_q;
        req_dat_d = req_dat_q;
        if (ack_d) begin
            req_we_d  = wbs_we_i;
            req_ok_d  = (wbs_sel_i == 4'hF);
            req_off_d = wbs_adr_i[7:0];
            req_dat_d = wbs_dat_i;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = req_dat_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok && !pop) count_d = count_q + CNT_ONE;
        else if (pop && !push_ok) count_d = count_q - CNT_ONE;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable_q && !empty) state_d = ST_ISSUE;
            ST_ISSUE: if (cmd_ready_i) state_d = ST_WAIT;
            ST_WAIT:  if (vau_done_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        enable_d  = enable_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        drained_d = drained_q;
        cyc_d     = cyc_q;
        if (ctrl_wr) begin
            enable_d = req_dat_q[0];
            irq_en_d = req_dat_q[2];
        end
        if (push & full) ovf_d = 1'b1;
        if (ctrl_wr & req_dat_q[3]) drained_d = 1'b0;
        if ((state_q == ST_WAIT) && vau_done_i && empty) drained_d = 1'b1;
        // Clear beats increment so a clear during a busy cycle reads back 0.
        if (ctrl_wr & req_dat_q[1]) begin
            cyc_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q != ST_IDLE) && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYC_ONE;
        end
        irq_d = drained_q & irq_en_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            req_we_q  <= 1'b0;
            req_ok_q  <= 1'b0;
            req_off_q <= '0;
            req_dat_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            enable_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            drained_q <= 1'b0;
            cyc_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            req_we_q  <= req_we_d;
            req_ok_q  <= req_ok_d;
            req_off_q <= req_off_d;
            req_dat_q <= req_dat_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            drained_q <= drained_d;
            cyc_q     <= cyc_d;
            irq_q     <= irq_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign cmd_o       = empty ? 32'd0 : mem_q[rd_ptr_q];
    assign cmd_valid_o = (state_q == ST_ISSUE);
    assign busy_o      = (state_q != ST_IDLE);
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_vau_cmd_sequencer.sv
// tb/tb_vau_cmd_sequencer.sv - Self-checking bench for vau_cmd_sequencer against a queue-based reference model.
module tb_vau_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        cmd_ready = 1'b0, done = 1'b0;
    logic        ack, ack2, cmd_valid, cmd_valid2, busy, busy2, irq, irq2;
    logic [31:0] rdat_o, rdat_o2, cmd, cmd2;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [31:0] mq [$];
    logic        m_ovf, m_drained;
    int          m_busy;

    always #5 clk = ~clk;

    vau_cmd_sequencer u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
        .cmd_o(cmd), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .vau_done_i(done),
        .busy_o(busy), .irq_o(irq)
    );

    vau_cmd_sequencer #(.CNT_W(4)) u_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack2), .wbs_dat_o(rdat_o2),
        .cmd_o(cmd2), .cmd_valid_o(cmd_valid2), .cmd_ready_i(cmd_ready), .vau_done_i(done),
        .busy_o(busy2), .irq_o(irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic acked,
                           output logic [31:0] r1, output logic [31:0] r2);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0; r1 = '0; r2 = '0;
        for (int i = 0; i < 6 && !acked; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1'b1;
                r1 = rdat_o;
                r2 = rdat_o2;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic a;
        logic [31:0] r1, r2;
        wb_xfer(1'b1, 32'h3000_0000 | 32'(off), d, 4'hF, a, r1, r2);
        check("write_ack", 32'(a), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic a;
        logic [31:0] r1, r2;
        wb_xfer(1'b0, 32'h3000_0000 | 32'(off), 32'd0, 4'hF, a, r1, r2);
        check({tag, "_ack"}, 32'(a), 32'd1);
        check(tag, r1, exp);
    endtask

    task automatic check_cycles(input string tag);
        logic a;
        logic [31:0] r1, r2;
        wb_xfer(1'b0, 32'h3000_000C, 32'd0, 4'hF, a, r1, r2);
        check({tag, "_cyc"}, r1, 32'(m_busy));
        check({tag, "_cyc4"}, r2, (m_busy > 15) ? 32'd15 : 32'(m_busy));
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        n = mq.size();
        return (32'(m_drained) << 9) | (32'(m_ovf) << 8) | (32'(n == 0) << 5)
             | (32'(n == 4) << 4) | 32'(n);
    endfunction

    task automatic push_cmd(input logic [31:0] d);
        wr(8'h00, d);
        if (mq.size() < 4) mq.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic clear_all();
        wr(8'h08, 32'h0000_000A);
        m_busy = 0; m_ovf = 1'b0; m_drained = 1'b0;
    endtask

    // One command: r stall cycles before ready, done in the d-th WAIT cycle (d >= 1).
    task automatic issue_one(input int r, input int d);
        logic found;
        logic [31:0] exp;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cmd_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("issue_seen", 32'(found), 32'd1);
        if (!found) return;
        exp = mq[0];
        for (int i = 0; i < r; i++) begin
            check("stall_valid", 32'(cmd_valid), 32'd1);
            check("stall_cmd", cmd, exp);
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        check("accept_cmd", cmd, exp);
        @(negedge clk);
        cmd_ready = 1'b0;
        void'(mq.pop_front());
        check("wait_valid", 32'(cmd_valid), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        for (int j = 1; j < d; j++) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("idle_gap_busy", 32'(busy), 32'd0);
        m_busy += r + 1 + d;
        if (mq.size() == 0) m_drained = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        logic [31:0] r1, r2;
        logic found;
        int n;

        m_busy = 0; m_ovf = 1'b0; m_drained = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_cmd", cmd, 32'd0);
        rd("reset_status", 8'h04, 32'h0000_0020);
        check_cycles("reset");

        // Address just above the window must not ack.
        wb_xfer(1'b0, 32'h3000_0104, 32'd0, 4'hF, a, r1, r2);
        check("miss_noack", 32'(a), 32'd0);
        // Partial byte-select write is acked and ignored.
        wb_xfer(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'h3, a, r1, r2);
        check("partial_sel_ack", 32'(a), 32'd1);
        rd("partial_sel_status", 8'h04, exp_status());

        push_cmd(32'hA5A5_0001);
        rd("one_status", 8'h04, exp_status());
        check("disabled_no_issue", 32'(cmd_valid), 32'd0);
        rd("cmd_reads_zero", 8'h00, 32'd0);
        rd("other_off_zero", 8'h20, 32'd0);
        wr(8'h08, 32'h0000_0001);
        check("valid_not_yet", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        check("valid_two_after_ack", 32'(cmd_valid), 32'd1);
        check("first_cmd", cmd, 32'hA5A5_0001);
        issue_one(0, 6);
        rd("ctrl_read", 8'h08, 32'h0000_0001);
        check_cycles("first");
        rd("first_status", 8'h04, exp_status());

        // Overflow: five pushes into four entries while disabled.
        clear_all();
        wr(8'h08, 32'h0000_0000);
        for (int i = 0; i < 5; i++) push_cmd(32'h1000_0000 + 32'(i));
        rd("full_status", 8'h04, exp_status());
        wr(8'h08, 32'h0000_0001);
        issue_one(10, 2);
        for (int i = 0; i < 3; i++) issue_one(0, 1);
        repeat (5) @(negedge clk);
        check("fifth_never_issued", 32'(cmd_valid), 32'd0);
        rd("ovf_status", 8'h04, exp_status());
        check_cycles("ovf");

        // Drained interrupt and its clear.
        wr(8'h08, 32'h0000_000E);
        m_busy = 0; m_ovf = 1'b0; m_drained = 1'b0;
        push_cmd(32'hC0DE_0001);
        wr(8'h08, 32'h0000_0005);
        issue_one(1, 1);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'd1);
        wr(8'h08, 32'h0000_000D);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);

        // Randomized rounds against the queue model.
        for (int round = 0; round < 6; round++) begin
            clear_all();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) push_cmd($urandom);
            rd("rnd_pre_status", 8'h04, exp_status());
            wr(8'h08, 32'h0000_0001);
            while (mq.size() > 0) issue_one($urandom_range(0, 4), $urandom_range(1, 6));
            rd("rnd_post_status", 8'h04, exp_status());
            check_cycles("rnd");
        end

        // Long command: narrow counter saturates, wide one keeps counting.
        clear_all();
        push_cmd(32'h5A7_0000);
        wr(8'h08, 32'h0000_0001);
        issue_one(5, 15);
        check_cycles("saturate");

        // Asynchronous reset in the middle of WAIT.
        clear_all();
        push_cmd(32'hBEEF_0001);
        wr(8'h08, 32'h0000_0001);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (cmd_valid) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_test_issue", 32'(found), 32'd1);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        @(negedge clk);
        check("mid_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_busy_fall", 32'(busy), 32'd0);
        check("async_valid_fall", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mq.delete();
        m_busy = 0; m_ovf = 1'b0; m_drained = 1'b0;
        rd("post_rst_status", 8'h04, 32'h0000_0020);
        rd("post_rst_ctrl", 8'h08, 32'h0000_0000);
        check_cycles("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
